// File: rtl/arbitro_memoria_instrucao.sv
// -----------------------------------------------------------------------------
// arbitro_memoria_instrucao
//
// Arbitrates a single-port instruction memory between a program loader and an
// instruction fetch unit. A four-state FSM (OCIOSO, CARGA, BUSCA, PARADO)
// decides who owns the memory. In CARGA the loader drives the memory port
// directly. In BUSCA words are fetched sequentially from an 8-bit pc into a
// one-entry output register with valid/ready handshake, branch redirect and a
// halt word that stops fetching.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   iniciar                    start fetching from OCIOSO or PARADO
//   carga_req                  loader requests the memory
//   carga_we/_end/_dado        loader write strobe, word index, data
//   carga_ack                  one-cycle pulse after each completed write
//   mem_end/_we/_wdado         memory word index, write enable, write data
//   mem_rdado                  combinational read data for mem_end
//   inst/inst_pc/inst_valid    registered instruction, its index, valid flag
//   inst_ready                 consumer accepts inst on valid && ready
//   desvio/desvio_alvo         branch redirect strobe and target index
//   parado                     high while halted
//   estado                     state code (0 OCIOSO, 1 CARGA, 2 BUSCA, 3 PARADO)
// -----------------------------------------------------------------------------
module arbitro_memoria_instrucao #(
    parameter logic [7:0]  PC_RESET    = 8'd0,
    parameter logic [31:0] CODIGO_HALT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        iniciar,
    input  logic        carga_req,
    input  logic        carga_we,
    input  logic [7:0]  carga_end,
    input  logic [31:0] carga_dado,
    output logic        carga_ack,
    output logic [7:0]  mem_end,
    output logic        mem_we,
    output logic [31:0] mem_wdado,
    input  logic [31:0] mem_rdado,
    output logic [31:0] inst,
    output logic [7:0]  inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        desvio,
    input  logic [7:0]  desvio_alvo,
    output logic        parado,
    output logic [1:0]  estado
);

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        CARGA  = 2'd1,
        BUSCA  = 2'd2,
        PARADO = 2'd3
    } estado_t;

    estado_t     estado_q, estado_d;
    logic [7:0]  pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [7:0]  inst_pc_q, inst_pc_d;
    logic        inst_valid_q, inst_valid_d;
    logic        carga_ack_q, carga_ack_d;
    logic        parado_q, parado_d;

    logic        em_carga;
    logic        pode_buscar;

    // Memory port: the loader owns it combinationally in CARGA; otherwise it
    // only ever reads at pc. Depends on state and loader inputs only, so no
    // path exists from inst_ready or desvio to any output.
    always_comb begin
        em_carga  = (estado_q == CARGA);
        mem_end   = em_carga ? carga_end : pc_q;
        mem_we    = em_carga & carga_we;
        mem_wdado = em_carga ? carga_dado : 32'h0000_0000;
    end

    always_comb begin
        estado_d     = estado_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = 1'b0;
        // A write accepted this cycle is acknowledged in the next one.
        carga_ack_d  = mem_we;
        // The output register is free when empty or being consumed now.
        pode_buscar  = !inst_valid_q || inst_ready;

        unique case (estado_q)
            OCIOSO, PARADO: begin
                if (carga_req) begin
                    estado_d = CARGA;
                end else if (iniciar) begin
                    estado_d = BUSCA;
                    pc_d     = PC_RESET;
                end
            end
            CARGA: begin
                if (!carga_req) begin
                    estado_d = OCIOSO;
                end
            end
            BUSCA: begin
                // Priority: loader takeover, then branch, then backpressure,
                // then halt detection, then a normal fetch.
                if (carga_req) begin
                    estado_d = CARGA;
                    pc_d     = PC_RESET;
                end else if (desvio) begin
                    pc_d = desvio_alvo;
                end else if (!pode_buscar) begin
                    inst_valid_d = inst_valid_q;
                end else if (mem_rdado == CODIGO_HALT) begin
                    estado_d = PARADO;
                end else begin
                    inst_d       = mem_rdado;
                    inst_pc_d    = pc_q;
                    inst_valid_d = 1'b1;
                    pc_d         = pc_q + 8'd1;
                end
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase

        parado_d = (estado_d == PARADO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q     <= OCIOSO;
            pc_q         <= PC_RESET;
            inst_q       <= 32'h0000_0000;
            inst_pc_q    <= 8'd0;
            inst_valid_q <= 1'b0;
            carga_ack_q  <= 1'b0;
            parado_q     <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            carga_ack_q  <= carga_ack_d;
            parado_q     <= parado_d;
        end
    end

    assign carga_ack  = carga_ack_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_valid = inst_valid_q;
    assign parado     = parado_q;
    assign estado     = estado_q;

endmodule

// File: tb/tb_arbitro_memoria_instrucao.sv
// -----------------------------------------------------------------------------
// tb_arbitro_memoria_instrucao
//
// Directed bench for arbitro_memoria_instrucao. A bench-side memory serves the
// DUT memory port. A cycle model holding mode, pc, the output register and its
// own copy of the program image predicts every output; a compare process checks
// the DUT against it on each falling edge, and the stimulus adds literal
// expectations at key points of each scenario.
// -----------------------------------------------------------------------------
module tb_arbitro_memoria_instrucao;

    localparam logic [7:0]  PC0  = 8'd0;
    localparam logic [31:0] HALT = 32'h0000_0000;
    localparam logic [1:0]  M_IDLE = 2'd0, M_LOAD = 2'd1, M_RUN = 2'd2, M_STOP = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iniciar, carga_req, carga_we;
    logic [7:0]  carga_end;
    logic [31:0] carga_dado;
    logic        carga_ack;
    logic [7:0]  mem_end;
    logic        mem_we;
    logic [31:0] mem_wdado, mem_rdado;
    logic [31:0] inst;
    logic [7:0]  inst_pc;
    logic        inst_valid, inst_ready, desvio;
    logic [7:0]  desvio_alvo;
    logic        parado;
    logic [1:0]  estado;

    int vectors = 0;
    int miscompares = 0;
    int n_ack = 0;
    int n_we = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    arbitro_memoria_instrucao #(.PC_RESET(PC0), .CODIGO_HALT(HALT)) dut (
        .clk(clk), .rst_n(rst_n), .iniciar(iniciar), .carga_req(carga_req),
        .carga_we(carga_we), .carga_end(carga_end), .carga_dado(carga_dado),
        .carga_ack(carga_ack), .mem_end(mem_end), .mem_we(mem_we),
        .mem_wdado(mem_wdado), .mem_rdado(mem_rdado), .inst(inst),
        .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .desvio(desvio), .desvio_alvo(desvio_alvo), .parado(parado),
        .estado(estado)
    );

    // Bench memory: written only through the DUT port, read combinationally.
    logic [31:0] tb_mem [256];
    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_end] <= mem_wdado;
    end
    assign mem_rdado = tb_mem[mem_end];

    // ---------------- reference model ----------------
    logic [1:0]  m_mode;
    logic [7:0]  m_pc;
    logic [31:0] m_inst;
    logic [7:0]  m_ipc;
    logic        m_vld, m_ack;
    logic [31:0] m_mem [256];

    always @(posedge clk) begin
        if (rst_n && m_mode == M_LOAD && carga_we) m_mem[carga_end] <= carga_dado;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= M_IDLE; m_pc <= PC0; m_inst <= 32'd0; m_ipc <= 8'd0;
            m_vld <= 1'b0; m_ack <= 1'b0;
        end else begin
            m_ack <= (m_mode == M_LOAD) && carga_we;
            m_vld <= 1'b0;
            if (m_mode == M_IDLE || m_mode == M_STOP) begin
                if (carga_req) m_mode <= M_LOAD;
                else if (iniciar) begin m_mode <= M_RUN; m_pc <= PC0; end
            end else if (m_mode == M_LOAD) begin
                if (!carga_req) m_mode <= M_IDLE;
            end else begin
                if (carga_req) begin
                    m_mode <= M_LOAD; m_pc <= PC0;
                end else if (desvio) begin
                    m_pc <= desvio_alvo;
                end else if (m_vld && !inst_ready) begin
                    m_vld <= 1'b1;
                end else if (m_mem[m_pc] == HALT) begin
                    m_mode <= M_STOP;
                end else begin
                    m_inst <= m_mem[m_pc]; m_ipc <= m_pc; m_vld <= 1'b1;
                    m_pc <= 8'((int'(m_pc) + 1) % 256);
                end
            end
        end
    end

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        vectors++;
        if (atual !== esperado) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nome, atual, esperado, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (carga_ack) n_ack <= n_ack + 1;
        if (mem_we) n_we <= n_we + 1;
        if (chk_en) begin
            check("estado", 32'(estado), 32'(m_mode));
            check("parado", 32'(parado), 32'(m_mode == M_STOP));
            check("inst_valid", 32'(inst_valid), 32'(m_vld));
            check("inst", inst, m_inst);
            check("inst_pc", 32'(inst_pc), 32'(m_ipc));
            check("carga_ack", 32'(carga_ack), 32'(m_ack));
            check("mem_we", 32'(mem_we), 32'(m_mode == M_LOAD && carga_we));
            if (m_mode == M_LOAD) begin
                check("mem_end_carga", 32'(mem_end), 32'(carga_end));
                check("mem_wdado_carga", mem_wdado, carga_dado);
            end else begin
                check("mem_wdado_zero", mem_wdado, 32'd0);
            end
            if (m_mode == M_RUN) check("mem_end_busca", 32'(mem_end), 32'(m_pc));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic escreve(input logic [7:0] e, input logic [31:0] d);
        carga_we = 1'b1; carga_end = e; carga_dado = d;
        cyc(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int s_ack, s_we;
        rst_n = 1'b0; iniciar = 1'b0; carga_req = 1'b0; carga_we = 1'b0;
        carga_end = 8'd0; carga_dado = 32'd0; inst_ready = 1'b0;
        desvio = 1'b0; desvio_alvo = 8'd0;
        cyc(1);
        chk_en = 1'b1;
        check("rst_estado", 32'(estado), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", 32'(inst_pc), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_carga_ack", 32'(carga_ack), 32'd0);
        check("rst_parado", 32'(parado), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        cyc(1);
        rst_n = 1'b1;

        // Load the three-word program.
        s_ack = n_ack; s_we = n_we;
        carga_req = 1'b1;
        cyc(1);
        check("load_estado", 32'(estado), 32'd1);
        escreve(8'd0, 32'h0000_2083);
        escreve(8'd1, 32'h0010_2023);
        escreve(8'd2, 32'h0000_0000);
        carga_we = 1'b0; carga_req = 1'b0;
        cyc(3);
        check("load_ack_pulses", 32'(n_ack - s_ack), 32'd3);
        check("load_we_cycles", 32'(n_we - s_we), 32'd3);

        // Run until the halt word at index 2.
        iniciar = 1'b1; inst_ready = 1'b1;
        cyc(1);
        iniciar = 1'b0;
        cyc(1);
        check("run0_pc", 32'(inst_pc), 32'd0);
        check("run0_inst", inst, 32'h0000_2083);
        cyc(1);
        check("run1_pc", 32'(inst_pc), 32'd1);
        check("run1_inst", inst, 32'h0010_2023);
        cyc(1);
        check("halt_parado", 32'(parado), 32'd1);
        check("halt_estado", 32'(estado), 32'd3);
        check("halt_valid", 32'(inst_valid), 32'd0);
        check("halt_model_pc", 32'(m_pc), 32'd2);
        check("halt_keep_pc", 32'(inst_pc), 32'd1);

        // Second load: indices 2..12 non-halt, 13 halt, 255 non-halt.
        carga_req = 1'b1;
        cyc(1);
        for (int i = 2; i <= 12; i++) escreve(8'(i), 32'hA000_0000 | 32'(i));
        escreve(8'd13, 32'h0000_0000);
        escreve(8'd255, 32'h0BAD_CAFE);
        carga_we = 1'b0; carga_req = 1'b0;
        cyc(1);

        // Backpressure; a stray loader write to index 3 must be ignored.
        carga_we = 1'b1; carga_end = 8'd3; carga_dado = 32'h0000_0000;
        iniciar = 1'b1; inst_ready = 1'b1;
        cyc(1);
        iniciar = 1'b0;
        cyc(2);
        check("bp_start_pc", 32'(inst_pc), 32'd1);
        inst_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            check("bp_hold_pc", 32'(inst_pc), 32'd1);
            check("bp_hold_inst", inst, 32'h0010_2023);
            check("bp_hold_mem_end", 32'(mem_end), 32'd2);
        end
        inst_ready = 1'b1;
        cyc(1);
        check("bp_release_pc", 32'(inst_pc), 32'd2);
        check("bp_release_inst", inst, 32'hA000_0002);
        cyc(1);
        check("pre_branch_pc", 32'(inst_pc), 32'd3);
        check("stray_write_ignored", inst, 32'hA000_0003);
        check("stray_no_ack", 32'(carga_ack), 32'd0);

        // Branch to 10.
        desvio = 1'b1; desvio_alvo = 8'd10;
        cyc(1);
        desvio = 1'b0;
        check("branch_bubble", 32'(inst_valid), 32'd0);
        cyc(1);
        check("branch_pc", 32'(inst_pc), 32'd10);
        check("branch_inst", inst, 32'hA000_000A);

        // Wrap from 255 to 0.
        desvio = 1'b1; desvio_alvo = 8'd255;
        cyc(1);
        desvio = 1'b0;
        cyc(1);
        check("wrap_255", 32'(inst_pc), 32'd255);
        check("wrap_255_inst", inst, 32'h0BAD_CAFE);
        cyc(1);
        check("wrap_0", 32'(inst_pc), 32'd0);
        check("wrap_0_inst", inst, 32'h0000_2083);

        // Branch beats halt: pc reaches 13 (halt word) with desvio high.
        cyc(12);
        check("pre_halt_pc", 32'(inst_pc), 32'd12);
        desvio = 1'b1; desvio_alvo = 8'd5;
        cyc(1);
        desvio = 1'b0;
        check("desvio_over_halt", 32'(estado), 32'd2);
        cyc(1);
        check("after_desvio5", 32'(inst_pc), 32'd5);

        // Loader takeover during backpressure.
        carga_we = 1'b0; inst_ready = 1'b0; carga_req = 1'b1;
        cyc(1);
        check("takeover_estado", 32'(estado), 32'd1);
        check("takeover_valid", 32'(inst_valid), 32'd0);
        check("takeover_keep_pc", 32'(inst_pc), 32'd5);

        // Reset in the middle of a write.
        carga_we = 1'b1; carga_end = 8'd5; carga_dado = 32'hDEAD_BEEF;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_mem_we", 32'(mem_we), 32'd0);
        check("midrst_estado", 32'(estado), 32'd0);
        check("midrst_valid", 32'(inst_valid), 32'd0);
        carga_req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(3);
        check("post_rst_no_ack", 32'(carga_ack), 32'd0);
        check("post_rst_estado", 32'(estado), 32'd0);
        check("post_rst_mem5", tb_mem[5], 32'hA000_0005);

        // carga_req wins over iniciar; the write now goes through.
        carga_req = 1'b1; iniciar = 1'b1;
        cyc(1);
        iniciar = 1'b0;
        check("req_wins", 32'(estado), 32'd1);
        cyc(1);
        carga_we = 1'b0;
        check("relaunch_ack", 32'(carga_ack), 32'd1);
        check("relaunch_mem5", tb_mem[5], 32'hDEAD_BEEF);
        carga_req = 1'b0;
        cyc(2);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
